// File: rtl/jtbubl_romrq_if.sv
// rtl/jtbubl_romrq_if.sv - client and SDRAM-arbiter signals of one ROM request slot
interface jtbubl_romrq_if #(
  parameter int AW = 18,
  parameter int DW = 8
);
  logic          clr;
  logic [AW-1:0] addr;
  logic          addr_ok;
  logic [DW-1:0] dout;
  logic          data_ok;
  logic          req;
  logic [21:0]   req_addr;
  logic          we;
  logic [31:0]   din;
  logic          din_ok;

  modport master (
    output clr, addr, addr_ok, we, din, din_ok,
    input  dout, data_ok, req, req_addr
  );

  modport slave (
    input  clr, addr, addr_ok, we, din, din_ok,
    output dout, data_ok, req, req_addr
  );
endinterface

// File: rtl/jtbubl_romrq.sv
// rtl/jtbubl_romrq.sv - single-client ROM slot with a one-line 32-bit cache
module jtbubl_romrq #(
  parameter int          AW     = 18,
  parameter int          DW     = 8,
  parameter logic [21:0] OFFSET = 22'd0
) (
  input  logic           clk,
  input  logic           rstn,
  jtbubl_romrq_if.slave  bus
);
  localparam int SB = (DW == 8) ? 2 : ((DW == 16) ? 1 : 0);
  localparam int TW = AW - SB;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  logic [1:0]    state;
  logic          valid;
  logic          req;
  logic [21:0]   req_addr;
  logic [TW-1:0] cached_tag;
  logic [TW-1:0] pend_tag;
  logic [31:0]   line;

  logic [TW-1:0] tag;
  logic          hit;
  logic [21:0]   line_addr;
  logic          fill;

  assign tag       = bus.addr[AW-1:SB];
  assign hit       = valid && (tag == cached_tag);
  assign line_addr = OFFSET + 22'({tag, 1'b0});

  // A fill completes either from WAIT or as a combined accept+data in REQ
  assign fill = bus.din_ok && ((state == WAIT) || (state == REQ && bus.we));

  assign bus.data_ok  = bus.addr_ok && hit && !bus.clr;
  assign bus.req      = req;
  assign bus.req_addr = req_addr;

  generate
    if (DW == 8) begin : g_lane8
      assign bus.dout = line[{bus.addr[1:0], 3'b000} +: DW];
    end else if (DW == 16) begin : g_lane16
      assign bus.dout = line[{bus.addr[0], 4'b0000} +: DW];
    end else begin : g_lane32
      assign bus.dout = line[DW-1:0];
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      valid      <= 1'b0;
      req        <= 1'b0;
      req_addr   <= OFFSET;
      cached_tag <= '0;
      pend_tag   <= '0;
      line       <= '0;
    end else if (bus.clr) begin
      // Invalidate wins over any fill arriving in the same cycle
      valid <= 1'b0;
      state <= IDLE;
      req   <= 1'b0;
    end else begin
      if (fill) begin
        line       <= bus.din;
        cached_tag <= pend_tag;
        valid      <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (bus.addr_ok && !hit) begin
            state    <= REQ;
            req      <= 1'b1;
            pend_tag <= tag;
            req_addr <= line_addr;
          end
        end
        REQ: begin
          if (bus.we) begin
            req   <= 1'b0;
            state <= bus.din_ok ? IDLE : WAIT;
          end
        end
        WAIT: begin
          if (bus.din_ok) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
